// File: rtl/spi_ram_arbiter.sv
// ---------------------------------------------------------------------------
// spi_ram_arbiter
//
// Two-master arbiter in front of a single-port synchronous RAM with a
// one-cycle registered read. Each cycle one master is granted
// combinationally. The winner's access drives the RAM in that same cycle.
// Read data comes back one cycle later. A registered owner tag steers
// readdatavalid to the master that issued the read.
//
// Arbitration (default build): fair round-robin with a hold limit. The
// current owner keeps the grant for at most MAX_HOLD consecutive accepted
// accesses while the other master is waiting. From IDLE, the master that
// was not granted most recently wins. After reset that master is m0.
//
// Optional feature: define SPI_RAM_ARB_PRIO_EN to give m0 strict priority.
// In that build MAX_HOLD no longer affects the grant, and m1 is served only
// when m0 is not requesting.
//
// Parameters
//   ADDR_W   : RAM word-address width
//   DATA_W   : data width (byteenable width is DATA_W/8)
//   MAX_HOLD : 1..15, grant-hold limit under contention
//
// Ports
//   clk, reset_n                       : clock, synchronous active-low reset
//   mX_read / mX_write                 : master X request (write wins if both)
//   mX_address/byteenable/writedata    : master X access fields
//   mX_waitrequest                     : 1 = master X not accepted this cycle
//   mX_readdata / mX_readdatavalid     : read return to master X
//   ram_address/byteenable/writedata   : RAM access fields (winner's)
//   ram_write, ram_chipselect          : RAM strobes
//   ram_clken                          : RAM clock enable, tied high
//   ram_readdata                       : RAM registered read data
// ---------------------------------------------------------------------------
module spi_ram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_write,
    output logic                ram_chipselect,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam logic [3:0] MAX_HOLD_L = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t     state_reg,    state_next;
    logic [3:0] hold_reg,     hold_next;
    logic       last_reg,     last_next;      // 0 = m0, 1 = m1 granted last
    logic       rd_valid_reg, rd_valid_next;
    logic       rd_owner_reg, rd_owner_next;  // master owning the read in flight

    logic req0, req1;
    logic grant_any;
    logic grant_sel;                          // 0 = m0, 1 = m1
    logic win_write;
    logic same_owner;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Write takes precedence when read and write are both asserted.
    assign win_write = grant_sel ? m1_write : m0_write;

    // ---------------------------------------------------------------------
    // Grant decision (combinational, from live requests + registered state)
    // ---------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (reset_n) begin
            if (req0 && !req1) begin
                grant_any = 1'b1;
                grant_sel = 1'b0;
            end else if (req1 && !req0) begin
                grant_any = 1'b1;
                grant_sel = 1'b1;
            end else if (req0 && req1) begin
                grant_any = 1'b1;
`ifdef SPI_RAM_ARB_PRIO_EN
                grant_sel = 1'b0;
`else
                case (state_reg)
                    // Owner keeps the grant until it has used up its hold.
                    ST_OWN0: grant_sel = (hold_reg >= MAX_HOLD_L);
                    ST_OWN1: grant_sel = !(hold_reg >= MAX_HOLD_L);
                    // From IDLE, favour whoever was not granted last.
                    default: grant_sel = ~last_reg;
                endcase
`endif
            end
        end
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            hold_reg     <= 4'd0;
            last_reg     <= 1'b1;   // pretend m1 went last so m0 is favoured
            rd_valid_reg <= 1'b0;
            rd_owner_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            last_reg     <= last_next;
            rd_valid_reg <= rd_valid_next;
            rd_owner_reg <= rd_owner_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    assign same_owner = grant_sel ? (state_reg == ST_OWN1) : (state_reg == ST_OWN0);

    always_comb begin
        state_next    = ST_IDLE;
        hold_next     = 4'd0;
        last_next     = last_reg;
        rd_valid_next = 1'b0;
        rd_owner_next = rd_owner_reg;
        if (grant_any) begin
            state_next    = grant_sel ? ST_OWN1 : ST_OWN0;
            last_next     = grant_sel;
            rd_valid_next = ~win_write;
            rd_owner_next = grant_sel;
            // Hold saturates at the limit. A lone requester may run past it
            // and the comparison still yields at the first contention.
            if (same_owner)
                hold_next = (hold_reg >= MAX_HOLD_L) ? MAX_HOLD_L : hold_reg + 4'd1;
            else
                hold_next = 4'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        ram_address    = grant_sel ? m1_address    : m0_address;
        ram_byteenable = grant_sel ? m1_byteenable : m0_byteenable;
        ram_writedata  = grant_sel ? m1_writedata  : m0_writedata;
        ram_chipselect = grant_any;
        ram_write      = grant_any & win_write;
        ram_clken      = 1'b1;

        m0_waitrequest = ~(grant_any & ~grant_sel);
        m1_waitrequest = ~(grant_any &  grant_sel);

        // Gating with reset_n drops a response that would land in the first
        // reset cycle, i.e. a read accepted just before reset.
        m0_readdatavalid = reset_n & rd_valid_reg & ~rd_owner_reg;
        m1_readdatavalid = reset_n & rd_valid_reg &  rd_owner_reg;

        m0_readdata = ram_readdata;
        m1_readdata = ram_readdata;
    end

endmodule
